ram_sync_loader: RTL and testbench

Initialisation front end for the synchronous block RAMs of the FPGA build. Accepts a byte stream over a valid/ready handshake (UART or debug link), optionally zero-fills the whole RAM, then packs bytes little-endian into words. The packed words drive the write port (waddr/wdata/we) of a `ram_sync_*` instance, e.g. instruction or data memory preload before the core leaves reset.

---
 rtl/ram_sync_loader_pkg.sv | 17 +
 rtl/ram_sync_byte_packer.sv | 70 +++++++
 rtl/ram_sync_loader.sv | 149 ++++++++++++++
 tb/tb_ram_sync_loader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_sync_loader_pkg.sv
// Shared constants for the block-RAM preload front end: default widths,
// FSM state codes and the load-length clamp.
package ram_sync_loader_pkg;

  localparam int unsigned ADDR_LEN = 8;
  localparam int unsigned DATA_LEN = 32;

  localparam logic [1:0] LDR_IDLE  = 2'd0;
  localparam logic [1:0] LDR_CLEAR = 2'd1;
  localparam logic [1:0] LDR_LOAD  = 2'd2;
  localparam logic [1:0] LDR_DONE  = 2'd3;

  function automatic int unsigned sat_len(input int unsigned len, input int unsigned depth);
    return (len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/ram_sync_byte_packer.sv
// Collects stream bytes little-endian into one RAM word; word_valid_o fires
// combinationally on the byte that completes the word.
module ram_sync_byte_packer #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_x,
  input  logic                  flush_i,
  input  logic                  take_i,
  input  logic [7:0]            byte_i,
  output logic                  word_valid_o,
  output logic [DATA_WIDTH-1:0] word_o
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [DATA_WIDTH-1:0] word_s;

  // Merge the incoming byte into its lane without disturbing earlier lanes
  always_comb begin
    word_s = word_q;
    for (int n = 0; n < int'(BYTES); n++) begin
      if (cnt_q == CNT_W'(n)) begin
        word_s[8*n +: 8] = byte_i;
      end else begin
        word_s[8*n +: 8] = word_q[8*n +: 8];
      end
    end
  end

  assign word_valid_o = take_i && (cnt_q == LAST_CNT);
  assign word_o       = word_s;

  // Outside LOAD the partial word is dropped so it can never reach the RAM
  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (flush_i) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (take_i) begin
      if (cnt_q == LAST_CNT) begin
        cnt_d  = '0;
        word_d = '0;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
        word_d = word_s;
      end
    end else begin
      cnt_d  = cnt_q;
      word_d = word_q;
    end
  end

  // Byte counter and partial word registers
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/ram_sync_loader.sv
// Preload front end for a ram_sync_* write port: optional zero-fill, then
// byte-stream packing into words with a registered waddr/wdata/we.
module ram_sync_loader
  import ram_sync_loader_pkg::*;
#(
  parameter int unsigned BRAM_ADDR_WIDTH = ADDR_LEN,
  parameter int unsigned BRAM_DATA_WIDTH = DATA_LEN,
  parameter int unsigned DATA_DEPTH      = 32
) (
  input  logic                       clk,
  input  logic                       reset_x,
  input  logic                       start,
  input  logic                       clear_en,
  input  logic [BRAM_ADDR_WIDTH-1:0] load_len,
  input  logic [7:0]                 byte_in,
  input  logic                       byte_valid,
  output logic                       byte_ready,
  output logic [BRAM_ADDR_WIDTH-1:0] waddr,
  output logic [BRAM_DATA_WIDTH-1:0] wdata,
  output logic                       we,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned AW = BRAM_ADDR_WIDTH;
  localparam int unsigned DW = BRAM_DATA_WIDTH;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DATA_DEPTH - 1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;

  logic [AW-1:0] start_len_s;
  logic [1:0]    after_clear_s;
  logic          take_s;
  logic          flush_s;
  logic          word_valid_s;
  logic [DW-1:0] word_s;

  assign start_len_s   = AW'(sat_len(32'(load_len), DATA_DEPTH));
  assign take_s        = byte_valid && (state_q == LDR_LOAD);
  assign flush_s       = (state_q != LDR_LOAD);
  assign after_clear_s = (len_q == '0) ? LDR_DONE : LDR_LOAD;

  ram_sync_byte_packer #(
    .DATA_WIDTH (DW)
  ) u_packer (
    .clk          (clk),
    .reset_x      (reset_x),
    .flush_i      (flush_s),
    .take_i       (take_s),
    .byte_i       (byte_in),
    .word_valid_o (word_valid_s),
    .word_o       (word_s)
  );

  // Sequencing and next write-port value; idx_q is the clear address or word index
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      LDR_IDLE: begin
        if (start) begin
          len_d = start_len_s;
          idx_d = '0;
          if (clear_en) begin
            we_d    = 1'b1;
            waddr_d = '0;
            wdata_d = '0;
            if (DATA_DEPTH == 1) begin
              state_d = (start_len_s == '0) ? LDR_DONE : LDR_LOAD;
            end else begin
              state_d = LDR_CLEAR;
              idx_d   = AW'(1);
            end
          end else if (start_len_s == '0) begin
            state_d = LDR_DONE;
          end else begin
            state_d = LDR_LOAD;
          end
        end else begin
          state_d = LDR_IDLE;
        end
      end
      LDR_CLEAR: begin
        we_d    = 1'b1;
        waddr_d = idx_q;
        wdata_d = '0;
        if (idx_q == LAST_ADDR) begin
          idx_d   = '0;
          state_d = after_clear_s;
        end else begin
          idx_d   = idx_q + AW'(1);
        end
      end
      LDR_LOAD: begin
        if (word_valid_s) begin
          we_d    = 1'b1;
          waddr_d = idx_q;
          wdata_d = word_s;
          idx_d   = idx_q + AW'(1);
          state_d = (idx_q == len_q - AW'(1)) ? LDR_DONE : LDR_LOAD;
        end else begin
          state_d = LDR_LOAD;
        end
      end
      LDR_DONE: begin
        state_d = LDR_IDLE;
      end
      default: begin
        state_d = LDR_IDLE;
      end
    endcase
  end

  // FSM, length latch, index and the registered RAM write port
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_q <= LDR_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign we         = we_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign byte_ready = (state_q == LDR_LOAD);
  assign busy       = (state_q == LDR_CLEAR) || (state_q == LDR_LOAD);
  assign done       = (state_q == LDR_DONE);

endmodule

// File: tb/tb_ram_sync_loader.sv
// Directed bench for ram_sync_loader: expected RAM writes are queued as stimulus
// is driven and checked by a write-port monitor as they appear.
module tb_ram_sync_loader;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset_x;
  logic          start;
  logic          clear_en;
  logic [AW-1:0] load_len;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          we;
  logic          busy;
  logic          done;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   wr_count = 0;

  ram_sync_loader #(
    .BRAM_ADDR_WIDTH (AW),
    .BRAM_DATA_WIDTH (DW),
    .DATA_DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_x    (reset_x),
    .start      (start),
    .clear_en   (clear_en),
    .load_len   (load_len),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .waddr      (waddr),
    .wdata      (wdata),
    .we         (we),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int k);
    return 8'(k * 7 + 3);
  endfunction

  // Write-port monitor: every we cycle must match the head of the scoreboard
  always @(negedge clk) begin
    if (reset_x && we) begin
      exp_t e;
      wr_count++;
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_write observed=%0h/%0h expected=none", waddr, wdata);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("waddr", 64'(waddr), 64'(e.addr));
        chk("wdata", 64'(wdata), 64'(e.data));
        chk("done_with_write", 64'(done), 64'(e.last));
      end
    end
  end

  task automatic do_start(input logic clr, input logic [AW-1:0] len);
    start    = 1'b1;
    clear_en = clr;
    load_len = len;
    @(posedge clk); #1;
    start    = 1'b0;
    clear_en = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    byte_in    = b;
    byte_valid = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (byte_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    chk("byte_accept", 64'(ok), 64'(1));
  endtask

  task automatic wait_done(input string tag, output bit rdy_seen);
    bit seen = 1'b0;
    rdy_seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (byte_ready) rdy_seen = 1'b1;
      if (done) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    bit   rdy;
    exp_t e;
    reset_x    = 1'b0;
    start      = 1'b0;
    clear_en   = 1'b0;
    load_len   = '0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_we", 64'(we), 64'(0));
    chk("rst_waddr", 64'(waddr), 64'(0));
    chk("rst_wdata", 64'(wdata), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_ready", 64'(byte_ready), 64'(0));
    @(posedge clk); #1;
    reset_x = 1'b1;
    @(posedge clk); #1;

    // Two words back-to-back, no clear
    wr_count = 0;
    e = '{addr: 8'd0, data: 32'h14131211, last: 1'b0}; sb.push_back(e);
    e = '{addr: 8'd1, data: 32'h18171615, last: 1'b1}; sb.push_back(e);
    do_start(1'b0, 8'd2);
    #3;
    chk("t1_busy", 64'(busy), 64'(1));
    for (int k = 0; k < 8; k++) send_byte(8'(8'h11 + k));
    byte_valid = 1'b0;
    wait_done("t1_done", rdy);
    chk("t1_writes", 64'(wr_count), 64'(2));
    chk("t1_sb_empty", 64'(sb.size()), 64'(0));

    // Zero-fill only; bytes offered meanwhile must not be taken
    wr_count = 0;
    for (int i = 0; i < DEPTH; i++) begin
      e = '{addr: 8'(i), data: 32'h0, last: (i == DEPTH - 1)};
      sb.push_back(e);
    end
    do_start(1'b1, 8'd0);
    byte_in    = 8'hC3;
    byte_valid = 1'b1;
    wait_done("t2_done", rdy);
    byte_valid = 1'b0;
    chk("t2_ready_low", 64'(rdy), 64'(0));
    chk("t2_writes", 64'(wr_count), 64'(DEPTH));
    chk("t2_sb_empty", 64'(sb.size()), 64'(0));

    // One byte every three cycles, single word
    wr_count = 0;
    e = '{addr: 8'd0, data: 32'hA4A3A2A1, last: 1'b1}; sb.push_back(e);
    do_start(1'b0, 8'd1);
    for (int k = 0; k < 3; k++) begin
      send_byte(8'(8'hA1 + k));
      byte_valid = 1'b0;
      byte_in    = 8'hFF;
      repeat (2) begin @(posedge clk); #1; end
    end
    chk("t3_no_early_write", 64'(wr_count), 64'(0));
    send_byte(8'hA4);
    byte_valid = 1'b0;
    wait_done("t3_done", rdy);
    chk("t3_writes", 64'(wr_count), 64'(1));

    // Oversized length saturates to DEPTH; a start mid-load is ignored
    wr_count = 0;
    for (int i = 0; i < DEPTH; i++) begin
      e = '{addr: 8'(i),
            data: {pat(4*i+3), pat(4*i+2), pat(4*i+1), pat(4*i)},
            last: (i == DEPTH - 1)};
      sb.push_back(e);
    end
    do_start(1'b0, 8'd40);
    for (int k = 0; k < 4 * DEPTH; k++) begin
      if (k == 50) begin
        start    = 1'b1;
        clear_en = 1'b1;
        load_len = 8'd3;
      end
      send_byte(pat(k));
      start    = 1'b0;
      clear_en = 1'b0;
    end
    byte_valid = 1'b0;
    wait_done("t4_done", rdy);
    byte_in    = 8'hEE;
    byte_valid = 1'b1;
    rdy = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (byte_ready) rdy = 1'b1;
    end
    byte_valid = 1'b0;
    chk("t4_extra_byte_refused", 64'(rdy), 64'(0));
    chk("t4_writes", 64'(wr_count), 64'(DEPTH));
    chk("t4_sb_empty", 64'(sb.size()), 64'(0));
    @(posedge clk); #1;

    // Reset after 6 of 8 bytes, then a fresh load from address 0
    wr_count = 0;
    e = '{addr: 8'd0, data: 32'h24232221, last: 1'b0}; sb.push_back(e);
    do_start(1'b0, 8'd2);
    for (int k = 0; k < 6; k++) send_byte(8'(8'h21 + k));
    byte_valid = 1'b0;
    reset_x = 1'b0;
    #1;
    chk("t5_rst_we", 64'(we), 64'(0));
    chk("t5_rst_waddr", 64'(waddr), 64'(0));
    chk("t5_rst_wdata", 64'(wdata), 64'(0));
    chk("t5_rst_busy", 64'(busy), 64'(0));
    chk("t5_rst_ready", 64'(byte_ready), 64'(0));
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    reset_x = 1'b1;
    @(posedge clk); #1;
    chk("t5_writes_before", 64'(wr_count), 64'(1));
    chk("t5_sb_empty_before", 64'(sb.size()), 64'(0));
    e = '{addr: 8'd0, data: 32'h34333231, last: 1'b1}; sb.push_back(e);
    do_start(1'b0, 8'd1);
    for (int k = 0; k < 4; k++) send_byte(8'(8'h31 + k));
    byte_valid = 1'b0;
    wait_done("t5_done", rdy);
    chk("t5_writes_after", 64'(wr_count), 64'(2));
    chk("t5_sb_empty", 64'(sb.size()), 64'(0));

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
